// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, WAIT_CYCLES wait states, one-cycle response pulse.
// Optional macro DMEM_CYCLE_COUNTER_EN maps a free-running cycle counter onto the all-ones address.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              commit, oor, is_ctr, err, mem_we;
  logic [DATA_W-1:0] mem_word, rd_word;

  // With zero wait states the commit edge is the accept edge, so use the live request.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign commit   = (state == WAIT && wait_cnt == 4'd1) ||
                    (state == IDLE && req_valid && WAIT_CYCLES == 0);
  assign oor      = 32'(cur_addr) >= DEPTH_U;
  assign mem_word = mem[cur_addr[IDX_W-1:0]];

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [DATA_W-1:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) cyc_cnt <= '0;
    else     cyc_cnt <= cyc_cnt + DATA_W'(1);
  end

  assign is_ctr  = (cur_addr == {ADDR_W{1'b1}});
  assign rd_word = is_ctr ? cyc_cnt : mem_word;
`else
  assign is_ctr  = 1'b0;
  assign rd_word = mem_word;
`endif

  assign err    = oor && !is_ctr;
  assign mem_we = !rst && commit && cur_we && !err && !is_ctr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr[IDX_W-1:0]] <= cur_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          wait_cnt  <= 4'(WAIT_CYCLES);
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd1) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (cur_we || err) ? '0 : rd_word;
      end
    end
  end
endmodule
